// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART emitter between the two store lanes (a, b) of the
//   dual-issue core. Both lanes may write in the same cycle. Accepted bytes
//   are queued in program order (lane a before lane b). Bytes then leave one
//   at a time through a registered head on a valid/ready interface.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   a_valid, a_data     lane a write strobe and byte
//   b_valid, b_data     lane b write strobe and byte
//   tx_data, tx_valid   registered head byte offered to the emitter
//   tx_ready            emitter ready; transfer when tx_valid && tx_ready
//   busy                fewer than two free entries (registered)
//   overflow            sticky; some write was dropped since reset
//   drained             queue empty and nothing pending on tx
//   count               queue occupancy, excluding the head register
module uart_tx_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [7:0]    a_data,
  input  logic          b_valid,
  input  logic [7:0]    b_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          overflow,
  output logic          drained,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]   wr1_ptr;
  logic [AW:0]     count_reg, count_next;
  logic [AW:0]     free;
  logic [7:0]      mem_reg [DEPTH];
  logic [7:0]      tx_data_reg;
  logic            overflow_reg;
  logic            busy_reg;

  logic            wr0_en, wr1_en;
  logic [7:0]      wr0_data, wr1_data;
  logic            drop;
  logic [1:0]      push_cnt;
  logic            load;
  logic [DEPTH-1:0] we0, we1;

  // ---------------------------------------------------------------------
  // Acceptance. Free space comes from the registered count only; a pop in
  // the same cycle is deliberately not credited, which keeps this path
  // independent of tx_ready. Port 0 always carries the older byte.
  // ---------------------------------------------------------------------
  always_comb begin
    free     = DEPTH_C - count_reg;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = a_data;
    wr1_data = b_data;
    drop     = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (free >= TWO_C) begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
        end else if (free == ONE_C) begin
          wr0_en = 1'b1;
          drop   = 1'b1;
        end else begin
          drop   = 1'b1;
        end
      end else if (a_valid || b_valid) begin
        wr0_data = a_valid ? a_data : b_data;
        if (free != '0) wr0_en = 1'b1;
        else            drop   = 1'b1;
      end
    end
  end

  assign push_cnt = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign wr1_ptr  = wr_ptr_reg + AW'(1);

  // Two writes per cycle, so each entry decodes its own write enables.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign we0[gi] = wr0_en && (wr_ptr_reg == AW'(gi));
    assign we1[gi] = wr1_en && (wr1_ptr    == AW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we0[i])      mem_reg[i] <= wr0_data;
      else if (we1[i]) mem_reg[i] <= wr1_data;
    end
  end

  // ---------------------------------------------------------------------
  // Output stage FSM: state register / next state / outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (count_reg != '0) state_next = SEND;
      SEND: if (tx_ready && count_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The head is refilled whenever it is empty or is being taken this cycle,
  // as long as the queue holds something. This gives back-to-back output.
  always_comb begin
    tx_valid = (state_reg == SEND);
    load     = (count_reg != '0) && ((state_reg == IDLE) || tx_ready);
  end

  // ---------------------------------------------------------------------
  // Pointers, occupancy, head register and status.
  // ---------------------------------------------------------------------
  assign count_next = count_reg + (AW+1)'(push_cnt) - (AW+1)'(load);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_data_reg  <= '0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_cnt);
      if (load) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        tx_data_reg <= mem_reg[rd_ptr_reg];
      end
      count_reg    <= count_next;
      overflow_reg <= overflow_reg | drop;
      // busy reflects the occupancy that will hold in the next cycle.
      busy_reg     <= (count_next >= DEPTH_C - ONE_C);
    end
  end

  assign tx_data  = tx_data_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign busy     = busy_reg;
  assign drained  = (count_reg == '0) && !tx_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, tx_ready;
  logic [7:0] a_data, b_data;
  logic [7:0] tx_data;
  logic       tx_valid, busy, overflow, drained;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data),
    .b_valid(b_valid), .b_data(b_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow), .drained(drained), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic dual(input logic [7:0] da, input logic [7:0] db);
    a_valid = 1'b1; a_data = da;
    b_valid = 1'b1; b_data = db;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int sent, rcvd, maxcnt;

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00; tx_ready = 1'b0;
    step(); step();
    check("rst_count", count, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_drained", drained, 1);
    reset = 1'b0;
    step();

    // Single byte: queued at the push edge, presented after the next edge.
    tx_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h41;
    step();
    a_valid = 1'b0;
    check("single_count_after_push", count, 1);
    check("single_valid_low_at_push", tx_valid, 0);
    step();
    check("single_valid", tx_valid, 1);
    check("single_data", tx_data, 8'h41);
    check("single_not_drained", drained, 0);
    step();
    check("single_valid_drop", tx_valid, 0);
    check("single_drained", drained, 1);

    // Same-cycle pair, emitter stalled.
    tx_ready = 1'b0;
    dual(8'h48, 8'h49);
    check("pair_count_push", count, 2);
    step();
    for (int i = 0; i < 4; i++) begin
      check("pair_hold_data", tx_data, 8'h48);
      check("pair_hold_count", count, 1);
      step();
    end
    check("pair_hold_valid", tx_valid, 1);
    tx_ready = 1'b1;
    step();
    check("pair_second_valid", tx_valid, 1);
    check("pair_second_data", tx_data, 8'h49);
    step();
    check("pair_done_valid", tx_valid, 0);
    check("pair_done_drained", drained, 1);

    // Fill and overflow.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) dual(8'(2*i), 8'(2*i+1));
    check("fill_count", count, 15);
    check("fill_head", tx_data, 8'h00);
    check("fill_busy", busy, 1);
    check("fill_overflow_clear", overflow, 0);
    dual(8'hF0, 8'hF1);
    check("ovf_count", count, 16);
    check("ovf_overflow", overflow, 1);
    check("ovf_busy", busy, 1);
    step();
    check("ovf_sticky", overflow, 1);
    tx_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp_b = (k < 16) ? 8'(k) : 8'hF0;
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, exp_b);
      step();
    end
    check("drain_empty_valid", tx_valid, 0);
    check("drain_drained", drained, 1);
    check("drain_overflow_sticky", overflow, 1);

    reset = 1'b1; step(); reset = 1'b0;
    check("reset_clears_overflow", overflow, 0);

    // Wrap-around: 40 bytes alternating lanes, producer honours busy,
    // emitter ready every third cycle.
    sent = 0; rcvd = 0; maxcnt = 0;
    for (int cyc = 0; cyc < 2000 && rcvd < 40; cyc++) begin
      tx_ready = (cyc % 3 == 2);
      a_valid = 1'b0; b_valid = 1'b0;
      if (sent < 40 && !busy) begin
        if (sent % 2 == 0) begin a_valid = 1'b1; a_data = 8'(8'h80 + sent); end
        else               begin b_valid = 1'b1; b_data = 8'(8'h80 + sent); end
        exp_q.push_back(8'(8'h80 + sent));
        sent++;
      end
      if (tx_valid && tx_ready) begin
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check("wrap_data", tx_data, exp_b);
        rcvd++;
      end
      if (int'(count) > maxcnt) maxcnt = int'(count);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0; tx_ready = 1'b0;
    check("wrap_received_all", rcvd, 40);
    check("wrap_count_bounded", (maxcnt <= 16), 1);
    check("wrap_no_overflow", overflow, 0);
    step();
    check("wrap_drained", drained, 1);

    // Push and pop in the same cycle keep the count steady.
    dual(8'h10, 8'h11);
    dual(8'h12, 8'h13);
    check("pp_setup_count", count, 3);
    check("pp_setup_valid", tx_valid, 1);
    check("pp_setup_head", tx_data, 8'h10);
    tx_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a_valid = 1'b1; a_data = 8'(8'h20 + k);
      step();
      exp_b = (k < 3) ? 8'(8'h11 + k) : 8'(8'h20 + k - 3);
      check("pp_count", count, 3);
      check("pp_valid", tx_valid, 1);
      check("pp_data", tx_data, exp_b);
    end
    a_valid = 1'b0; tx_ready = 1'b0;

    // Reset mid-operation with a strobe during reset.
    dual(8'h30, 8'h31);
    dual(8'h32, 8'h33);
    check("mid_count", count, 7);
    check("mid_valid", tx_valid, 1);
    reset = 1'b1; a_valid = 1'b1; a_data = 8'hEE;
    step();
    reset = 1'b0; a_valid = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_valid", tx_valid, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_drained", drained, 1);
    check("midrst_busy", busy, 0);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst_no_tx", tx_valid, 0);
    end
    check("midrst_final_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between the two IO store lanes (a, b) of the dual-issue core.
- Both lanes can issue a UART write in the same cycle. The block accepts both writes, orders them by program order (lane a older than lane b), and buffers them in a FIFO.
- It then feeds bytes one at a time to the emitter's valid/ready interface.
- It also exports a busy flag for software polling and a drained flag used before halt.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- AW, $clog2(DEPTH): pointer width; the occupancy count is AW+1 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  lane a UART write strobe (one cycle per store)
- a_data  in  8  lane a byte
- b_valid  in  1  lane b UART write strobe
- b_data  in  8  lane b byte
- tx_data  out  8  byte presented to the UART emitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  emitter ready; a transfer occurs when tx_valid and tx_ready are both high
- busy  out  1  fewer than 2 free entries (software polls this in place of !uart_ready)
- overflow  out  1  sticky: a write was dropped
- drained  out  1  FIFO empty and no byte pending on tx
- count  out  AW+1  current occupancy, for debug and bench

Behaviour:
- Reset (synchronous, active-high):
  - Pointers and count return to 0; tx_valid=0, tx_data=0, overflow=0, busy=0, drained=1.
  - Reset asserted mid-transfer flushes all entries; bytes in flight are lost.
  - A strobe arriving in the same cycle as reset is ignored.
- Acceptance:
  - free = DEPTH - count, using the registered count only. A same-cycle pop is not credited.
  - Both strobes with free>=2: a is written at wr_ptr, b at wr_ptr+1, and wr_ptr advances by 2.
  - Both strobes with free==1: a is accepted, b is dropped, overflow set.
  - Both strobes with free==0: both dropped, overflow set.
  - One strobe with free>=1: that byte is written at wr_ptr, and wr_ptr advances by 1.
  - One strobe with free==0: dropped, overflow set.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never wraps.
- Output stage: a registered head, two states.
  - IDLE: tx_valid=0. Entering when count was 0 at a push cycle, tx_valid rises the cycle after the push (latency 1). In the same edge tx_data loads mem[rd_ptr], rd_ptr increments, and count decrements. Go to SEND.
  - SEND: tx_valid=1; tx_data is held stable while tx_ready=0.
    - Transfer with count>0: load the next entry the same edge, so tx_valid stays 1 (back-to-back, one byte per cycle if tx_ready stays high). Stay in SEND.
    - Transfer with count==0: tx_valid=0 next cycle; go to IDLE.
- Count update per edge: count_next = count + pushes(0,1,2) - load(0,1). A simultaneous push and load are both applied.
- Status outputs:
  - busy = (DEPTH - count) < 2, registered from count_next.
  - drained = (count==0) && !tx_valid.
  - overflow clears only on reset.
- Ordering guarantee: transmit order equals acceptance order; a precedes b within a cycle.

Test Plan:
- Single byte: after reset, a_valid=1, a_data=8'h41 for one cycle, tx_ready=1 → tx_valid=1 with tx_data=8'h41 exactly one cycle later; tx_valid=0 the next cycle; drained returns to 1.
- Same-cycle pair: a_data=8'h48 and b_data=8'h49 in one cycle, tx_ready held 0 for 5 cycles then 1 → count=1 while tx_data=8'h48 is held stable; then 8'h48 and 8'h49 transfer on consecutive cycles.
- Fill and overflow (DEPTH=16, tx_ready=0): 8 dual strobes with bytes 0..15, then one more dual strobe with 8'hF0/8'hF1.
  - After the 8 dual strobes: count=15, tx_data=8'h00 held, busy=1, overflow=0.
  - After the extra strobe: 8'hF0 is accepted (count=16), 8'hF1 is dropped, overflow=1.
- Wrap-around: stream 40 bytes alternating lanes with tx_ready=1 every third cycle → the output sequence equals the input order with no loss; count never exceeds 16.
- Push and pop in the same cycle: hold count=3, tx_ready=1, and a_valid=1 each cycle → count stays 3 and tx_valid stays continuously 1.
- Reset mid-operation: count=7 with tx_valid=1, assert reset for 1 cycle → next cycle count=0, tx_valid=0, overflow=0, drained=1; a strobe issued during reset is not transmitted.
